// File: rtl/store_monitor.sv
// store_monitor: pass/fail/timeout completion checker on the ARM store bus.
// Optional store trace FIFO enabled by defining STORE_MONITOR_TRACE_EN.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] IGNORE_ADDR    = 32'd96,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       store_count,
  output logic [31:0]      last_adr,
  output logic [31:0]      last_data
`ifdef STORE_MONITOR_TRACE_EN
  ,
  input  logic             trace_rd,
  output logic [31:0]      trace_adr,
  output logic [31:0]      trace_data,
  output logic             trace_empty,
  output logic             trace_ovf
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam int TO_M1 =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = TO_M1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cc;
  logic [7:0]       r_sc;
  logic [31:0]      r_la;
  logic [31:0]      r_ld;

  logic [CNT_W-1:0] w_cc_nxt;
  logic [7:0]       w_sc_nxt;
  logic             w_pass_hit;
  logic             w_ign_hit;
  logic             w_to_hit;

  assign w_cc_nxt = (r_cc == CNT_MAX) ? r_cc : r_cc + 1'b1;
  assign w_sc_nxt = (r_sc == 8'hFF) ? r_sc : r_sc + 8'd1;
  assign w_pass_hit = (DataAdr == PASS_ADDR) &&
                      (WriteData == PASS_DATA);
  assign w_ign_hit = (DataAdr == IGNORE_ADDR);
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cc == TO_LAST);

  // Run/terminal FSM; a store decision outranks a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_RUN;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_cc      <= '0;
      r_sc      <= '0;
      r_la      <= '0;
      r_ld      <= '0;
    end else if (r_state == S_RUN) begin
      if (MemWrite) begin
        r_cc <= w_cc_nxt;
        r_sc <= w_sc_nxt;
        r_la <= DataAdr;
        r_ld <= WriteData;
        if (w_pass_hit) begin
          r_state <= S_PASS;
          r_pass  <= 1'b1;
          r_done  <= 1'b1;
        end else if (!w_ign_hit) begin
          r_state <= S_FAIL;
          r_fail  <= 1'b1;
          r_done  <= 1'b1;
        end
      end else if (w_to_hit) begin
        r_state   <= S_TIMEOUT;
        r_timeout <= 1'b1;
        r_done    <= 1'b1;
      end else begin
        r_cc <= w_cc_nxt;
      end
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign cycle_count = r_cc;
  assign store_count = r_sc;
  assign last_adr    = r_la;
  assign last_data   = r_ld;

`ifdef STORE_MONITOR_TRACE_EN
  logic [63:0] r_mem [8];
  logic [2:0]  r_wp;
  logic [2:0]  r_rp;
  logic [3:0]  r_cnt;
  logic        r_ovf;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_acc;

  assign w_push  = (r_state == S_RUN) && MemWrite;
  assign w_empty = (r_cnt == 4'd0);
  assign w_full  = (r_cnt == 4'd8);
  assign w_pop   = trace_rd && !w_empty;
  assign w_acc   = w_push && (!w_full || w_pop);

  // Trace pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_acc) r_wp <= r_wp + 3'd1;
      if (w_pop) r_rp <= r_rp + 3'd1;
      if (w_acc && !w_pop) r_cnt <= r_cnt + 4'd1;
      else if (!w_acc && w_pop) r_cnt <= r_cnt - 4'd1;
      if (w_push && !w_acc) r_ovf <= 1'b1;
    end
  end

  // Trace storage; stale contents are harmless once pointers reset.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wp] <= {DataAdr, WriteData};
  end

  assign trace_adr   = r_mem[r_rp][63:32];
  assign trace_data  = r_mem[r_rp][31:0];
  assign trace_empty = w_empty;
  assign trace_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: randomized and directed checks of store_monitor
// against a queue-based reference model of the completion rules.
module tb_store_monitor;

  localparam int CNT_W = 16;
  localparam int TO    = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             MemWrite;
  logic [31:0]      DataAdr;
  logic [31:0]      WriteData;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [7:0]       store_count;
  logic [31:0]      last_adr;
  logic [31:0]      last_data;
  logic             trace_rd;
`ifdef STORE_MONITOR_TRACE_EN
  logic [31:0]      trace_adr;
  logic [31:0]      trace_data;
  logic             trace_empty;
  logic             trace_ovf;
`endif

  store_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .store_count (store_count),
    .last_adr    (last_adr),
    .last_data   (last_data)
`ifdef STORE_MONITOR_TRACE_EN
    ,
    .trace_rd    (trace_rd),
    .trace_adr   (trace_adr),
    .trace_data  (trace_data),
    .trace_empty (trace_empty),
    .trace_ovf   (trace_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          m_pass, m_fail, m_to;
  int          m_cc, m_sc;
  logic [31:0] m_la, m_ld;
  logic [63:0] mq[$];
  bit          m_ovf;

  logic [115:0] got_v, exp_v;

  function automatic logic [115:0] exp_vec();
    logic [CNT_W-1:0] cc;
    logic [7:0]       sc;
    cc = m_cc[CNT_W-1:0];
    sc = m_sc[7:0];
    return {12'd0, m_pass | m_fail | m_to, m_pass, m_fail, m_to,
            cc, sc, m_la, m_ld};
  endfunction

  function automatic logic [115:0] got_vec();
    return {12'd0, done, pass, fail, timeout,
            cycle_count, store_count, last_adr, last_data};
  endfunction

  // One clock: drive inputs, advance model, settle past the edge.
  task automatic tick(input bit rst_n, input bit we,
                      input logic [31:0] adr, input logic [31:0] dat,
                      input bit rd);
    bit running;
    bit pop;
    reset = rst_n; MemWrite = we; DataAdr = adr;
    WriteData = dat; trace_rd = rd;
    @(posedge clk);
    running = !(m_pass || m_fail || m_to);
    if (!rst_n) begin
      m_pass = 0; m_fail = 0; m_to = 0;
      m_cc = 0; m_sc = 0; m_la = 0; m_ld = 0;
      mq.delete(); m_ovf = 0;
    end else begin
      pop = rd && mq.size() > 0;
      if (pop) void'(mq.pop_front());
      if (running && we) begin
        if (mq.size() < 8) mq.push_back({adr, dat});
        else m_ovf = 1;
      end
      if (running) begin
        if (we) begin
          m_cc = (m_cc < 65535) ? m_cc + 1 : m_cc;
          m_sc = (m_sc < 255) ? m_sc + 1 : m_sc;
          m_la = adr; m_ld = dat;
          if (adr == 100 && dat == 7) m_pass = 1;
          else if (adr != 96) m_fail = 1;
        end else if (TO != 0 && m_cc == TO - 1) begin
          m_to = 1;
        end else begin
          m_cc = (m_cc < 65535) ? m_cc + 1 : m_cc;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 32'd100, 32'd7, 0);
      n_cmp++;
      if (got_vec() !== 116'd0) begin
        n_bad++;
        $display("FAIL reset_hold: got %h want 0", got_vec());
      end
    end
    tick(1, 0, 0, 0, 0);
    n_cmp++;
    if (cycle_count !== 16'd1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: cc %0d done %b want 1 0",
               cycle_count, done);
    end
  endtask

  task automatic test_timeout();
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 1010; i++) begin
      tick(1, 0, 0, 0, 0);
      got_v = got_vec(); exp_v = exp_vec();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL timeout_cyc%0d: got %h want %h",
                 i, got_v, exp_v);
      end
      if (i == 998) begin
        n_cmp++;
        if (cycle_count !== 16'd999 || timeout !== 1'b0) begin
          n_bad++;
          $display("FAIL timeout_pre: cc %0d to %b want 999 0",
                   cycle_count, timeout);
        end
      end
    end
    n_cmp++;
    if ({done, timeout, pass, fail} !== 4'b1100 ||
        cycle_count !== 16'd999) begin
      n_bad++;
      $display("FAIL timeout_final: dtpf %b%b%b%b cc %0d want 1100 999",
               done, timeout, pass, fail, cycle_count);
    end
  endtask

  task automatic test_pass_seq();
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 32'd96, 32'd5, 0);
    tick(1, 1, 32'd96, 32'd12, 0);
    n_cmp++;
    if (done !== 1'b0 || store_count !== 8'd2) begin
      n_bad++;
      $display("FAIL pass_ignore: done %b sc %0d want 0 2",
               done, store_count);
    end
    tick(1, 1, 32'd100, 32'd7, 0);
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1100 ||
        store_count !== 8'd3 || last_adr !== 32'd100 ||
        last_data !== 32'd7) begin
      n_bad++;
      $display("FAIL pass_seq: dpft %b%b%b%b sc %0d la %0d ld %0d want 1100 3 100 7",
               done, pass, fail, timeout,
               store_count, last_adr, last_data);
    end
    idle(3);
    n_cmp++;
    if (got_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL pass_sticky: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_fail();
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 32'd100, 32'd8, 0);
    n_cmp++;
    if ({done, pass, fail} !== 3'b101 || last_data !== 32'd8) begin
      n_bad++;
      $display("FAIL fail_wrongdata: dpf %b%b%b ld %0d want 101 8",
               done, pass, fail, last_data);
    end
    tick(1, 1, 32'd100, 32'd7, 0);
    n_cmp++;
    if (fail !== 1'b1 || pass !== 1'b0 || store_count !== 8'd1 ||
        last_data !== 32'd8) begin
      n_bad++;
      $display("FAIL fail_sticky: f %b p %b sc %0d ld %0d want 1 0 1 8",
               fail, pass, store_count, last_data);
    end
  endtask

  task automatic test_store_at_timeout();
    tick(0, 0, 0, 0, 0);
    idle(999);
    tick(1, 1, 32'd100, 32'd7, 0);
    n_cmp++;
    if (pass !== 1'b1 || timeout !== 1'b0 || fail !== 1'b0) begin
      n_bad++;
      $display("FAIL store_vs_timeout: p %b t %b f %b want 1 0 0",
               pass, timeout, fail);
    end
  endtask

  task automatic test_reset_midrun();
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 32'd100, 32'd7, 0);
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (got_vec() !== 116'd0) begin
      n_bad++;
      $display("FAIL reset_in_pass: got %h want 0", got_vec());
    end
    tick(1, 1, 32'd96, 32'd1, 0);
    tick(1, 1, 32'd96, 32'd2, 0);
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (got_vec() !== 116'd0) begin
      n_bad++;
      $display("FAIL reset_midrun: got %h want 0", got_vec());
    end
    tick(1, 0, 0, 0, 0);
    n_cmp++;
    if (cycle_count !== 16'd1 || store_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_restart: cc %0d sc %0d want 1 0",
               cycle_count, store_count);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 20; run++) begin
      tick(0, 0, 0, 0, 0);
      for (int c = 0; c < int'($urandom_range(50, 400)); c++) begin
        bit          we, rs, rd;
        logic [31:0] a, d;
        int          r;
        we = ($urandom_range(0, 5) == 0);
        r  = $urandom_range(0, 15);
        a  = (r < 12) ? 32'd96 : (r < 14) ? 32'd100 : $urandom;
        d  = ($urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
        rs = ($urandom_range(0, 199) != 0);
        rd = ($urandom_range(0, 3) == 0);
        tick(rs, we, a, d, rd);
        got_v = got_vec(); exp_v = exp_vec();
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL rand_r%0d_c%0d: got %h want %h",
                   run, c, got_v, exp_v);
        end
`ifdef STORE_MONITOR_TRACE_EN
        n_cmp++;
        if (trace_empty !== (mq.size() == 0) || trace_ovf !== m_ovf ||
            (mq.size() > 0 && {trace_adr, trace_data} !== mq[0])) begin
          n_bad++;
          $display("FAIL rand_trace_r%0d_c%0d: e %b o %b head %h want %b %b %h",
                   run, c, trace_empty, trace_ovf,
                   {trace_adr, trace_data}, mq.size() == 0, m_ovf,
                   (mq.size() > 0) ? mq[0] : 64'd0);
        end
`endif
      end
    end
  endtask

`ifdef STORE_MONITOR_TRACE_EN
  task automatic test_trace();
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (trace_empty !== 1'b1 || trace_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL trace_reset: e %b o %b want 1 0",
               trace_empty, trace_ovf);
    end
    for (int i = 1; i <= 10; i++) tick(1, 1, 32'd96, i, 0);
    n_cmp++;
    if (trace_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL trace_ovf: got %b want 1", trace_ovf);
    end
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (trace_empty !== 1'b0 || trace_adr !== 32'd96 ||
          trace_data !== i) begin
        n_bad++;
        $display("FAIL trace_pop%0d: e %b adr %0d data %0d want 0 96 %0d",
                 i, trace_empty, trace_adr, trace_data, i);
      end
      tick(1, 0, 0, 0, 1);
    end
    tick(1, 0, 0, 0, 1);
    n_cmp++;
    if (trace_empty !== 1'b1 || trace_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL trace_drain: e %b o %b want 1 1",
               trace_empty, trace_ovf);
    end
  endtask
`endif

  initial begin
    reset = 0; MemWrite = 0; DataAdr = 0; WriteData = 0; trace_rd = 0;
    test_reset();
    test_timeout();
    test_pass_seq();
    test_fail();
    test_store_at_timeout();
    test_reset_midrun();
`ifdef STORE_MONITOR_TRACE_EN
    test_trace();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
Synthesizable completion checker that sits directly downstream of the single-cycle ARM `top`. It watches the processor's data-memory store bus (MemWrite/DataAdr/WriteData) and decides pass, fail or timeout. It replaces per-bench negedge checking with a registered pass/fail result, usable both in simulation and on FPGA LEDs.

Parameters:
PASS_ADDR, 32'd100, store address that signals program success
PASS_DATA, 32'd7, data that must accompany PASS_ADDR
IGNORE_ADDR, 32'd96, scratch address; stores here are legal and do not end the run
TIMEOUT_CYCLES, 1000, cycles in RUN before timeout is declared; 0 disables timeout
CNT_W, 16, width of cycle counter

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-low reset
MemWrite  in  1  store strobe from top, one store per asserted cycle
DataAdr  in  32  store address from top
WriteData  in  32  store data from top
done  out  1  any terminal state reached
pass  out  1  run succeeded
fail  out  1  illegal store seen
timeout  out  1  no terminal store within TIMEOUT_CYCLES
cycle_count  out  CNT_W  cycles spent in RUN, saturating
store_count  out  8  stores observed, saturating at 255
last_adr  out  32  address of most recent store
last_data  out  32  data of most recent store

Behaviour:
- Reset (reset==0 at rising clk): state=RUN; all outputs 0. Reset has priority over every other event, including mid-run and in terminal states.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset.
- RUN, each clk:
  - cycle_count += 1, saturating at 2^CNT_W-1.
  - If MemWrite=1: store_count += 1 (saturating); last_adr and last_data are captured.
    - DataAdr==PASS_ADDR && WriteData==PASS_DATA -> PASS.
    - Else if DataAdr==IGNORE_ADDR -> stay in RUN.
    - Else -> FAIL. This includes PASS_ADDR with wrong data.
  - Else if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
- Simultaneous store and timeout on the same cycle: the store decision wins.
- Latency: flags are registered and assert in the cycle after the deciding edge. done = pass|fail|timeout, all registered.
- Terminal states: counters, last_adr and last_data freeze. Later stores are ignored.
- Exactly one of pass/fail/timeout is ever 1.
- MemWrite with X/Z inputs is not handled; the bench must drive known values.

Optional Feature:
Macro STORE_MONITOR_TRACE_EN.
- Defined:
  - Adds an 8-entry trace FIFO holding {DataAdr, WriteData} for every store observed in RUN.
  - Extra ports: trace_rd in 1, trace_adr out 32, trace_data out 32, trace_empty out 1, trace_ovf out 1.
  - trace_adr and trace_data show the head entry combinationally. trace_rd pops when not empty; pop on empty is ignored.
  - When full, new stores are dropped and trace_ovf sets sticky.
  - Simultaneous push and pop when full: the pop occurs and the push is accepted.
  - Reset clears the FIFO and trace_ovf; after reset trace_empty=1.
- Undefined: the extra ports and the FIFO do not exist; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released, no stores -> all flags 0; cycle_count increments 1/cycle; timeout=1 the cycle after cycle_count hits 999; done=1, cycle_count frozen at 999.
- Stores (96,5), (96,12), then (100,7) -> store_count=3; pass=1 one cycle after the (100,7) edge; last_adr=100, last_data=7.
- Store (100,8) -> fail=1; last_data=8; a following (100,7) leaves fail=1, pass=0, store_count=1.
- Store (100,7) on the same cycle timeout would trigger (cycle 999) -> pass=1, timeout=0.
- reset=0 pulsed while in PASS, and separately mid-RUN after 2 stores -> next cycle all outputs 0, state RUN, counting restarts from 0.
- With STORE_MONITOR_TRACE_EN, 10 stores to 96 with data 1..10, then 8 pops -> data 1..8 returned in order; trace_ovf=1; trace_empty=1 after 8th pop; extra pop ignored.
